// File: rtl/e_dec_digits.sv
// Fraction-to-decimal stage of the e calculator: streams the fraction words of a
// fixed-point result as decimal digits, most significant first, by repeated x10.
module e_dec_digits #(
  parameter int WORDS      = 32,
  parameter int NUM_DIGITS = 16,
  parameter int IDX_W      = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      in_data [0:WORDS-1],
  output logic             busy,
  output logic             done,
  output logic [15:0]      int_part,
  output logic [3:0]       digit,
  output logic [IDX_W-1:0] digit_idx,
  output logic             digit_valid,
  input  logic             digit_ready
);

  // frac_reg[k] holds input word k+1, so pointer 0 is the most significant word.
  localparam int FW  = WORDS - 1;
  localparam int J_W = (FW > 1) ? $clog2(FW) : 1;

  typedef enum logic [1:0] {IDLE, MUL, EMIT} state_t;

  state_t         state_reg;
  logic [15:0]    frac_reg [0:FW-1];
  logic [J_W-1:0] j_reg;
  logic [3:0]     carry_reg;
  logic [19:0]    prod;

  assign prod = 20'(frac_reg[j_reg]) * 20'd10 + 20'(carry_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      int_part    <= '0;
      digit       <= '0;
      digit_idx   <= '0;
      digit_valid <= 1'b0;
      j_reg       <= '0;
      carry_reg   <= '0;
      for (int i = 0; i < FW; i++) frac_reg[i] <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < FW; i++) frac_reg[i] <= in_data[i+1];
            int_part  <= in_data[0];
            done      <= 1'b0;
            busy      <= 1'b1;
            digit_idx <= '0;
            j_reg     <= J_W'(FW - 1);
            carry_reg <= '0;
            state_reg <= MUL;
          end
        end
        MUL: begin
          frac_reg[j_reg] <= prod[15:0];
          carry_reg       <= prod[19:16];
          // The carry out of the top fraction word is the next decimal digit.
          if (j_reg == '0) begin
            digit       <= prod[19:16];
            digit_valid <= 1'b1;
            state_reg   <= EMIT;
          end else begin
            j_reg <= j_reg - 1'b1;
          end
        end
        EMIT: begin
          if (digit_ready) begin
            digit_valid <= 1'b0;
            if (digit_idx == IDX_W'(NUM_DIGITS - 1)) begin
              done      <= 1'b1;
              busy      <= 1'b0;
              state_reg <= IDLE;
            end else begin
              digit_idx <= digit_idx + 1'b1;
              j_reg     <= J_W'(FW - 1);
              carry_reg <= '0;
              state_reg <= MUL;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/e_dec_digits.md
Name: e_dec_digits

Overview:
- Downstream stage of the e calculator. Takes the multi-word fixed-point result array (integer word plus fraction words) and converts the fraction to decimal digits, most significant first.
- Method: repeated word-serial multiply-by-10 of the fraction register.
- Digits stream out over a valid/ready handshake to the display/UART formatter; the integer part is presented as a binary word.

Parameters:
- WORDS, 32, total 16-bit words in the input array (≥2). Word 0 is the integer part. Words 1..WORDS-1 are the fraction, word 1 most significant.
- NUM_DIGITS, 16, number of fraction decimal digits emitted per conversion (1..1024).
- IDX_W, 10, width of digit_idx (≥ ceil(log2(NUM_DIGITS))).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request conversion; sampled only in IDLE.
- in_data  in  16 x [0:WORDS-1]  fixed-point value; captured on the accepted start edge.
- busy  out  1  high in MUL and EMIT.
- done  out  1  sticky; set when the last digit is accepted, cleared by the next accepted start.
- int_part  out  16  captured in_data[0]; held until the next accepted start.
- digit  out  4  current decimal digit, 0..9.
- digit_idx  out  IDX_W  position of the current digit, 0 = first after the decimal point.
- digit_valid  out  1  digit/digit_idx valid.
- digit_ready  in  1  consumer accepts when digit_valid && digit_ready at a rising edge.

Behaviour:
- Reset: state=IDLE. busy=0, done=0, int_part=0, digit=0, digit_idx=0, digit_valid=0. Fraction register and carry are zeroed. Reset wins over all other inputs in the same cycle, including mid-conversion: any partial output is abandoned and no further digits are emitted.
- States: IDLE, MUL, EMIT.
- IDLE + start:
  - frac[1..WORDS-1] <= in_data[1..WORDS-1]; int_part <= in_data[0].
  - done <= 0, digit_idx <= 0, word pointer j <= WORDS-1, carry <= 0.
  - Next state MUL.
- Start outside IDLE is ignored, with no effect on any output.
- MUL, one fraction word per cycle, from least significant (j=WORDS-1) to most significant (j=1):
  - p = frac[j]*10 + carry. p is 20 bits, max 655359.
  - frac[j] <= p[15:0]; carry <= p[19:16].
  - After updating j=1: digit <= p[19:16], digit_valid <= 1, next state EMIT.
  - MUL therefore lasts exactly WORDS-1 cycles. digit_valid rises WORDS-1 cycles after the edge that accepted start (or the edge that accepted the previous digit).
- EMIT:
  - digit and digit_idx are held stable while digit_ready=0, for unbounded backpressure.
  - On the accepting edge: digit_valid <= 0.
  - If digit_idx == NUM_DIGITS-1: done <= 1, next state IDLE.
  - Otherwise: digit_idx <= digit_idx+1, j <= WORDS-1, carry <= 0, next state MUL.
- digit_ready may be high before digit_valid rises. Acceptance requires both signals high at the same edge. digit_ready has no effect outside EMIT.
- Start asserted in the same cycle that the last digit is accepted is ignored, because the state is still EMIT.
- Carry into the integer part is discarded; int_part is never modified by the conversion.
- Digits are truncated, not rounded. Accuracy is limited to about 4.8*(WORDS-1) digits; later digits are exact for the truncated binary value.

Test Plan:
- WORDS=4, NUM_DIGITS=10, in_data={0x0002,0xB7E1,0x5162,0x8AED}, digit_ready=1 -> int_part=2; digits 7,1,8,2,8,1,8,2,8,4 with digit_idx 0..9; each digit_valid rises 3 cycles after the previous acceptance; done=1 after the 10th accept; busy=0 afterwards.
- Fraction {0x8000,0,0}, NUM_DIGITS=4 -> digits 5,0,0,0. Fraction all 0xFFFF -> ten 9s. Fraction all zero -> ten 0s.
- Backpressure: digit_ready low for 7 cycles on digit 3 -> digit and digit_idx stable and digit_valid stays high throughout; no digit skipped or duplicated; the sequence is unchanged versus the first test.
- start pulsed while busy with a different in_data -> ignored; output sequence and int_part unchanged; done stays 0 until completion.
- rst high for 1 cycle during MUL of digit 4 -> all outputs zero next cycle. A subsequent start with the first-test input produces the full correct sequence from digit_idx 0.
- Back-to-back: start in the cycle after done rises -> done clears, busy=1, and the new conversion produces correct digits.
